// File: rtl/pair_seq_ctrl_if.sv
// Bus between pair_seq_ctrl and its input RAM, pair datapath and output RAM.
// master = sequencer side, slave = RAM/datapath side.
interface pair_seq_ctrl_if #(
    parameter int K = 3
);
    logic         inpRAMen;
    logic [K:0]   addr;
    logic         dp_start;
    logic         dp_done;
    logic         outRAMwr;
    logic [K-1:0] out_addr;

    modport master (
        output inpRAMen, addr, dp_start, outRAMwr, out_addr,
        input  dp_done
    );

    modport slave (
        input  inpRAMen, addr, dp_start, outRAMwr, out_addr,
        output dp_done
    );
endinterface

// File: rtl/pair_seq_ctrl.sv
// pair_seq_ctrl: walks all 2^K operand pairs (read, launch, wait, write), then pulses done.
// Define TIMEOUT_EN to add a per-pair WAIT watchdog with an ABORT state and sticky error flag.
module pair_seq_ctrl #(
    parameter int N       = 16,
    parameter int K       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    pair_seq_ctrl_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [K-1:0]    err_idx
);
    if (N < 1 || K < 1 || TIMEOUT < 2) begin : g_param_check
        $error("pair_seq_ctrl: N and K must be >= 1, TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
`ifdef TIMEOUT_EN
        S_ABORT,
`endif
        S_DONE
    } state_t;

    state_t       state, state_next;
    logic [K-1:0] idx;
    logic         last_pair;
    logic         pair_end;

    assign last_pair = (idx == {K{1'b1}});

`ifdef TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] wait_cnt;
    logic          wait_expired;

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
    assign pair_end     = (state == S_WRITE) || (state == S_ABORT);
`else
    assign pair_end     = (state == S_WRITE);
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_READ;
            S_READ:   state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.dp_done) state_next = S_WRITE;
`ifdef TIMEOUT_EN
                else if (wait_expired) state_next = S_ABORT;
`endif
            end
`ifdef TIMEOUT_EN
            S_ABORT:  state_next = last_pair ? S_DONE : S_READ;
`endif
            S_WRITE:  state_next = last_pair ? S_DONE : S_READ;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // idx only wraps through the explicit clear after the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == S_IDLE && start) begin
            idx <= '0;
        end else if (pair_end) begin
            idx <= last_pair ? '0 : idx + K'(1);
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && !bus.dp_done) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Error flag survives the pass; only an accepted start or reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            err_idx     <= '0;
        end else if (state == S_IDLE && start) begin
            timeout_err <= 1'b0;
        end else if (state == S_ABORT) begin
            timeout_err <= 1'b1;
            err_idx     <= idx;
        end
    end
`else
    assign timeout_err = 1'b0;
    assign err_idx     = '0;
`endif

    assign bus.inpRAMen = (state == S_READ);
    assign bus.addr     = {1'b0, idx};
    assign bus.dp_start = (state == S_LAUNCH);
    assign bus.outRAMwr = (state == S_WRITE);
    assign bus.out_addr = idx;
    assign done         = (state == S_DONE);
    assign busy         = (state != S_IDLE) && (state != S_DONE);
endmodule

// File: tb/tb_pair_seq_ctrl.sv
// Self-checking bench for pair_seq_ctrl: datapath responder plus address/write scoreboards.
// Build with TIMEOUT_EN defined to also exercise the abort path (TIMEOUT=4).
module tb_pair_seq_ctrl;
    localparam int K  = 3;
    localparam int NP = 1 << K;
`ifdef TIMEOUT_EN
    localparam int  TIMEOUT_P = 4;
    localparam bit  TO_EN     = 1'b1;
`else
    localparam int  TIMEOUT_P = 64;
    localparam bit  TO_EN     = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic [K-1:0] err_idx;

    pair_seq_ctrl_if #(.K(K)) bus ();

    pair_seq_ctrl #(.N(16), .K(K), .TIMEOUT(TIMEOUT_P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .err_idx     (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int addr_q[$];
    int wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.inpRAMen, bus.addr, bus.dp_start, bus.outRAMwr, bus.out_addr,
                    busy, done, timeout_err, err_idx});
    endfunction

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        start   = 1'b0;
        bus.dp_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(tag, all_outs(), 32'h0);
        rst_n = 1'b1;
    endtask

    // lat[i] = WAIT cycle on which dp_done is returned for pair i (1 = first); 0 = never.
    task automatic run_pass(input int lat [NP], input bit hold, input bit spur);
        int  exp_cost [NP];
        int  exp_total, n_wr_exp, c0, c_done, last_read, pair;
        int  busy_cnt, dps_cnt, wr_cnt, wait_left, exp_err_idx;
        bit  armed, got_done, exp_err;

        addr_q.delete();
        wr_q.delete();
        exp_total = 0; n_wr_exp = 0; exp_err = 1'b0; exp_err_idx = 0;
        for (int i = 0; i < NP; i++) begin
            addr_q.push_back(i);
            if (lat[i] != 0) begin
                wr_q.push_back(i);
                n_wr_exp++;
            end else begin
                exp_err = 1'b1;
                exp_err_idx = i;
            end
            exp_cost[i] = 3 + ((lat[i] == 0) ? TIMEOUT_P : lat[i]);
            exp_total  += exp_cost[i];
        end
        pair = 0; last_read = 0; busy_cnt = 0; dps_cnt = 0; wr_cnt = 0;
        wait_left = 0; armed = 1'b0; got_done = 1'b0; c_done = 0;

        start = 1'b1;
        bus.dp_done = spur;
        c0 = cyc;
        tick();
        if (!hold) start = 1'b0;

        for (int i = 0; i < 600 && !got_done; i++) begin
            bus.dp_done = 1'b0;
            if (bus.inpRAMen) begin
                armed = 1'b0;
                if (addr_q.size() == 0) check("extra_read", 32'(bus.addr), 32'hFFFF);
                else                    check("read_addr", 32'(bus.addr), addr_q.pop_front());
                if (pair > 0) check("pair_cost", cyc - last_read, exp_cost[pair-1]);
                last_read = cyc;
                pair++;
                if (spur) bus.dp_done = 1'b1;
            end
            if (bus.dp_start) begin
                dps_cnt++;
                armed = 1'b1;
                wait_left = (pair > 0 && pair <= NP) ? lat[pair-1] : 1;
            end else if (armed) begin
                if (wait_left == 1) begin
                    bus.dp_done = 1'b1;
                    armed = 1'b0;
                end else if (wait_left > 1) begin
                    wait_left--;
                end
            end
            if (bus.outRAMwr) begin
                wr_cnt++;
                if (wr_q.size() == 0) check("extra_write", 32'(bus.out_addr), 32'hFFFF);
                else                  check("write_addr", 32'(bus.out_addr), wr_q.pop_front());
                if (spur) bus.dp_done = 1'b1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got_done = 1'b1;
                c_done   = cyc;
            end else begin
                tick();
            end
        end

        check("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check("done_cycle", c_done - c0, 1 + exp_total);
            check("last_cost", c_done - last_read, exp_cost[NP-1]);
            check("busy_cycles", busy_cnt, exp_total);
            check("dp_start_count", dps_cnt, NP);
            check("write_count", wr_cnt, n_wr_exp);
            check("timeout_err", 32'(timeout_err), 32'(TO_EN && exp_err));
            check("err_idx", 32'(err_idx), (TO_EN && exp_err) ? exp_err_idx : 0);
            bus.dp_done = spur;
            tick();
            check("idle_after_done", 32'({busy, done, bus.inpRAMen}), 32'h0);
            if (hold) begin
                bus.dp_done = 1'b0;
                tick();
                check("restart_read", 32'(bus.inpRAMen), 32'd1);
                check("restart_addr", 32'(bus.addr), 32'd0);
                start = 1'b0;
            end
        end
        bus.dp_done = 1'b0;
    endtask

    initial begin
        int  lat [NP];
        int  cur;
        bit  give, found;

        rst_n = 1'b0;
        start = 1'b0;
        bus.dp_done = 1'b0;
        do_reset("reset_outputs");

        // Immediate dp_done on every pair.
        for (int i = 0; i < NP; i++) lat[i] = 1;
        run_pass(lat, 1'b0, 1'b0);

        // Variable datapath latency on the first three pairs.
        lat[0] = 1; lat[1] = 5; lat[2] = 2;
        run_pass(lat, 1'b0, 1'b0);

        // start held high, spurious dp_done outside WAIT.
        for (int i = 0; i < NP; i++) lat[i] = 1;
        run_pass(lat, 1'b1, 1'b1);
        do_reset("reset_after_hold");

        // Reset asserted mid-WAIT on pair 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        cur = -1; give = 1'b0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            bus.dp_done = give;
            give = 1'b0;
            if (bus.inpRAMen) cur = int'(bus.addr);
            if (bus.dp_start) begin
                if (cur == 5) found = 1'b1;
                else          give  = 1'b1;
            end
            if (!found) tick();
        end
        check("reached_pair5", 32'(found), 32'd1);
        bus.dp_done = 1'b0;
        tick();
        tick();
        check("wait_pair5", 32'({busy, bus.out_addr}), 32'({1'b1, 3'd5}));
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset_read", 32'({bus.inpRAMen, bus.addr}), 32'({1'b1, 4'd0}));
        do_reset("reset_after_restart");

`ifdef TIMEOUT_EN
        // Pair 3 never answers: abort, no write, later pairs still processed.
        for (int i = 0; i < NP; i++) lat[i] = 1;
        lat[3] = 0;
        run_pass(lat, 1'b0, 1'b0);

        // dp_done on the final allowed WAIT cycle wins over the timeout; error clears on start.
        lat[3] = TIMEOUT_P;
        run_pass(lat, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
